// File: rtl/aes_pkg.sv
// Shared AES types, field arithmetic and S-box functions.
// The S-boxes are computed from the GF(2^8) inverse and affine map instead of a lookup table.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and it maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_round_engine_if.sv
// Block handshake plus the round-key lookup channel of the AES round engine.
interface aes_round_engine_if;
    import aes_pkg::*;

    logic       IN_VALID;
    logic       IN_READY;
    logic       IN_DECRYPT;
    aes_state_t IN_DATA;
    logic [3:0] KEY_IDX;
    aes_state_t KEY_IN;
    logic       OUT_VALID;
    logic       OUT_READY;
    aes_state_t OUT_DATA;

    modport slave (
        input  IN_VALID, IN_DECRYPT, IN_DATA, KEY_IN, OUT_READY,
        output IN_READY, KEY_IDX, OUT_VALID, OUT_DATA
    );

    modport master (
        output IN_VALID, IN_DECRYPT, IN_DATA, KEY_IN, OUT_READY,
        input  IN_READY, KEY_IDX, OUT_VALID, OUT_DATA
    );
endinterface

// File: rtl/aes_round_step.sv
// Combinational single AES round step, forward or inverse, selected by mode.
// first = bare AddRoundKey; last = final round without (Inv)MixColumns.
module aes_round_step
    import aes_pkg::*;
#(
    parameter bit ENABLE_DEC = 1'b1
) (
    input  aes_state_t state_i,
    input  aes_state_t rk_i,
    input  logic       mode_i,
    input  logic       first_i,
    input  logic       last_i,
    output aes_state_t state_o
);

    function automatic aes_state_t sub_bytes(input aes_state_t s, input logic inv);
        aes_state_t r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    // Byte 4*c+r sits in column c, row r; row r rotates left by r (right for inverse).
    function automatic aes_state_t shift_rows(input aes_state_t s, input logic inv);
        aes_state_t r;
        int         src;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                src = inv ? (c - w + 4) % 4 : (c + w) % 4;
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*src+w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        if (inv)
            return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                    gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                    gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                    gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s, input logic inv);
        aes_state_t r;
        for (int c = 0; c < 4; c++)
            r[127-32*c -: 32] = mix_col(s[127-32*c -: 32], inv);
        return r;
    endfunction

    aes_state_t enc_sr, enc_next, dec_next;

    assign enc_sr   = shift_rows(sub_bytes(state_i, 1'b0), 1'b0);
    assign enc_next = first_i ? (state_i ^ rk_i)
                              : ((last_i ? enc_sr : mix_columns(enc_sr, 1'b0)) ^ rk_i);

    generate
        if (ENABLE_DEC) begin : g_dec
            aes_state_t dec_ark;
            // Inverse cipher applies the key before InvMixColumns.
            assign dec_ark  = sub_bytes(shift_rows(state_i, 1'b1), 1'b1) ^ rk_i;
            assign dec_next = first_i ? (state_i ^ rk_i)
                                      : (last_i ? dec_ark : mix_columns(dec_ark, 1'b1));
        end else begin : g_no_dec
            assign dec_next = enc_next;
        end
    endgenerate

    assign state_o = (ENABLE_DEC && mode_i) ? dec_next : enc_next;

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES engine: one round step per clock over a shared datapath,
// with round keys fetched combinationally from an external store via KEY_IDX.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NR         = NR_128,
    parameter bit ENABLE_DEC = 1'b1
) (
    input logic               clk,
    input logic               rst,
    aes_round_engine_if.slave bus
);

    fsm_e       fsm_q, fsm_d;
    logic [3:0] rnd_q, rnd_d;
    logic       mode_q, mode_d;
    aes_state_t state_q, state_d;
    aes_state_t step_out;
    logic       in_ready, accept;

    // A DONE block being drained frees the engine in the same cycle.
    assign in_ready      = (fsm_q == IDLE) || ((fsm_q == DONE) && bus.OUT_READY);
    assign accept        = bus.IN_VALID && in_ready;
    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = (fsm_q == DONE);
    assign bus.OUT_DATA  = state_q;
    assign bus.KEY_IDX   = (fsm_q != RUN) ? 4'd0 : (mode_q ? (4'(NR) - rnd_q) : rnd_q);

    aes_round_step #(
        .ENABLE_DEC(ENABLE_DEC)
    ) u_step (
        .state_i (state_q),
        .rk_i    (bus.KEY_IN),
        .mode_i  (mode_q),
        .first_i (rnd_q == 4'd0),
        .last_i  (rnd_q == 4'(NR)),
        .state_o (step_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        state_d = state_q;
        case (fsm_q)
            RUN: begin
                state_d = step_out;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == 4'(NR)) begin
                    fsm_d = DONE;
                    rnd_d = 4'd0;
                end
            end
            DONE:    if (bus.OUT_READY) fsm_d = IDLE;
            IDLE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
        if (accept) begin
            fsm_d   = RUN;
            rnd_d   = 4'd0;
            mode_d  = bus.IN_DECRYPT & ENABLE_DEC;
            state_d = bus.IN_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            mode_q  <= 1'b0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed FIPS-197 vectors against three engine builds (AES-128, AES-256, no-decrypt),
// with round keys served from a table-based key-expansion model.
module tb_aes_round_engine;

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KB  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic         iv [3];
    logic         idec [3];
    logic         ordy [3];
    logic [127:0] idat [3];
    logic         ir [3];
    logic         ov [3];
    logic [127:0] odat [3];
    logic [3:0]   kidx [3];
    logic [127:0] rk_tab [0:2][0:14];
    logic [127:0] sb_rows [0:15];
    logic [3:0]   kseq [0:15];

    aes_round_engine_if bus0 ();
    aes_round_engine_if bus1 ();
    aes_round_engine_if bus2 ();

    assign bus0.IN_VALID   = iv[0];
    assign bus0.IN_DECRYPT = idec[0];
    assign bus0.IN_DATA    = idat[0];
    assign bus0.OUT_READY  = ordy[0];
    assign bus0.KEY_IN     = (bus0.KEY_IDX <= 4'd14) ? rk_tab[0][bus0.KEY_IDX] : '0;
    assign ir[0]   = bus0.IN_READY;
    assign ov[0]   = bus0.OUT_VALID;
    assign odat[0] = bus0.OUT_DATA;
    assign kidx[0] = bus0.KEY_IDX;

    assign bus1.IN_VALID   = iv[1];
    assign bus1.IN_DECRYPT = idec[1];
    assign bus1.IN_DATA    = idat[1];
    assign bus1.OUT_READY  = ordy[1];
    assign bus1.KEY_IN     = (bus1.KEY_IDX <= 4'd14) ? rk_tab[1][bus1.KEY_IDX] : '0;
    assign ir[1]   = bus1.IN_READY;
    assign ov[1]   = bus1.OUT_VALID;
    assign odat[1] = bus1.OUT_DATA;
    assign kidx[1] = bus1.KEY_IDX;

    assign bus2.IN_VALID   = iv[2];
    assign bus2.IN_DECRYPT = idec[2];
    assign bus2.IN_DATA    = idat[2];
    assign bus2.OUT_READY  = ordy[2];
    assign bus2.KEY_IN     = (bus2.KEY_IDX <= 4'd14) ? rk_tab[2][bus2.KEY_IDX] : '0;
    assign ir[2]   = bus2.IN_READY;
    assign ov[2]   = bus2.OUT_VALID;
    assign odat[2] = bus2.OUT_DATA;
    assign kidx[2] = bus2.KEY_IDX;

    aes_round_engine #(.NR(10), .ENABLE_DEC(1'b1)) u_dut    (.clk(clk), .rst(rst), .bus(bus0));
    aes_round_engine #(.NR(14), .ENABLE_DEC(1'b1)) u_dut14  (.clk(clk), .rst(rst), .bus(bus1));
    aes_round_engine #(.NR(10), .ENABLE_DEC(1'b0)) u_dut_ne (.clk(clk), .rst(rst), .bus(bus2));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        row = sb_rows[x[7:4]];
        return row[127-8*int'(x[3:0]) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
    endfunction

    task automatic expand(input int g, input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= 14; r++)
            if (r <= nr) rk_tab[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_tab[g][r] = '0;
    endtask

    // Offer one block from IDLE, return the result and edges from accept to OUT_VALID.
    task automatic run_one(input int g, input logic dec, input logic [127:0] din,
                           output logic [127:0] dout, output int lat);
        iv[g]   = 1'b1;
        idec[g] = dec;
        idat[g] = din;
        @(posedge clk); #1;
        iv[g] = 1'b0;
        lat = 0;
        while (!ov[g] && lat < 40) begin
            if (lat < 16) kseq[lat] = kidx[g];
            @(posedge clk); #1;
            lat++;
        end
        dout = odat[g];
    endtask

    task automatic drain();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] d, hold;
        int           lat, n, bad;
        sb_rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
        sb_rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
        sb_rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
        sb_rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
        sb_rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
        sb_rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
        sb_rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
        sb_rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
        sb_rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
        sb_rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
        sb_rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
        sb_rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
        sb_rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
        sb_rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
        sb_rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
        sb_rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
        for (int g = 0; g < 3; g++) begin
            iv[g] = 1'b0; idec[g] = 1'b0; idat[g] = '0; ordy[g] = 1'b1;
        end
        expand(0, K1, 4);
        expand(1, K3, 8);
        expand(2, K1, 4);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", ir[0], 1);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_out_data", odat[0], 0);
        chk("rst_key_idx", kidx[0], 0);
        rst = 1'b0;

        run_one(0, 1'b0, PT1, d, lat);
        chk("c1_enc", d, CT1);
        chk("c1_latency", lat, 11);
        chk("c1_enc_kidx3", kseq[3], 3);
        drain();
        chk("c1_drained", ov[0], 0);
        chk("c1_idle_ready", ir[0], 1);

        run_one(0, 1'b1, CT1, d, lat);
        chk("c1_dec", d, PT1);
        for (int i = 0; i <= 10; i++) chk($sformatf("dec_kidx%0d", i), kseq[i], 10 - i);
        drain();

        expand(0, KB, 4);
        run_one(0, 1'b0, PTB, d, lat);
        chk("b_enc", d, CTB);
        iv[0] = 1'b1; idec[0] = 1'b1; idat[0] = odat[0];
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("b2b_ov_low", ov[0], 0);
        chk("b2b_accepted", ir[0], 0);
        n = 1;
        while (!ov[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_period", n, 12);
        chk("b2b_dec", odat[0], PTB);
        drain();

        expand(0, K1, 4);
        ordy[0] = 1'b0;
        run_one(0, 1'b0, PT1, d, lat);
        hold = odat[0];
        iv[0] = 1'b1; idec[0] = 1'b0; idat[0] = PTB;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (odat[0] !== hold || ov[0] !== 1'b1 || ir[0] !== 1'b0 || kidx[0] !== 4'd0) bad++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_data", hold, CT1);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        #1;
        chk("bp_ready_rise", ir[0], 1);
        @(posedge clk); #1;
        chk("bp_transfer", ov[0], 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ov[0] !== 1'b0) bad++;
        end
        chk("bp_single", bad, 0);

        iv[0] = 1'b1; idec[0] = 1'b0; idat[0] = PT1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_kidx5", kidx[0], 5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ov", ov[0], 0);
        chk("mid_rst_data", odat[0], 0);
        chk("mid_rst_ready", ir[0], 1);
        iv[0] = 1'b1;
        @(posedge clk); #1;
        chk("rst_wins", ir[0], 1);
        iv[0] = 1'b0;
        rst = 1'b0;
        run_one(0, 1'b0, PT1, d, lat);
        chk("post_rst_enc", d, CT1);
        drain();

        run_one(1, 1'b0, PT1, d, lat);
        chk("c3_enc", d, CT3);
        chk("c3_latency", lat, 15);
        drain();

        run_one(2, 1'b1, PT1, d, lat);
        chk("nodec_enc", d, CT1);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
